// File: rtl/uart_tx_core.sv
// 8N1 UART transmitter with a one-byte holding buffer, so consecutive frames
// go out with no idle gap. The TX pin is driven straight from a flop.
module uart_tx_core #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic                 buf_full;
    logic [DATA_BITS-1:0] buf_data;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] shift_nxt;

    logic accept;
    logic end_bit;
    logic stop_end;
    logic load_buf;
    logic load_in;
    logic buf_wr;

    assign tx_ready  = ~buf_full;
    assign busy      = (state != IDLE) | buf_full;
    assign accept    = tx_valid & tx_ready;
    assign end_bit   = (cnt == CNT_LAST);
    assign stop_end  = (state == STOP) & end_bit;
    assign shift_nxt = shift >> 1;

    // A new frame starts either from the holding buffer or straight from the
    // input; the buffer always has priority so byte order is preserved.
    assign load_buf = buf_full & ((state == IDLE) | stop_end);
    assign load_in  = accept & ((state == IDLE) | stop_end);
    assign buf_wr   = accept & (state != IDLE) & ~stop_end;

    always_ff @(posedge clk) begin
        if (load_buf) begin
            shift <= buf_data;
        end else if (load_in) begin
            shift <= tx_data;
        end else if ((state == DATA) && end_bit) begin
            shift <= shift_nxt;
        end
        if (buf_wr) begin
            buf_data <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            tx       <= 1'b1;
            buf_full <= 1'b0;
            cnt      <= '0;
            bit_idx  <= '0;
        end else begin
            if (state == IDLE) begin
                cnt <= '0;
            end else begin
                cnt <= end_bit ? '0 : cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (buf_full) begin
                        state    <= START;
                        tx       <= 1'b0;
                        buf_full <= 1'b0;
                    end else if (accept) begin
                        state <= START;
                        tx    <= 1'b0;
                    end
                end
                START: begin
                    if (end_bit) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        tx      <= shift[0];
                    end
                end
                DATA: begin
                    if (end_bit) begin
                        if (bit_idx == IDX_LAST) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx      <= shift_nxt[0];
                        end
                    end
                end
                STOP: begin
                    if (end_bit) begin
                        if (buf_full) begin
                            state    <= START;
                            tx       <= 1'b0;
                            buf_full <= 1'b0;
                        end else if (accept) begin
                            state <= START;
                            tx    <= 1'b0;
                        end else begin
                            state <= IDLE;
                            tx    <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase

            if (buf_wr) begin
                buf_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core: a line monitor decodes every frame on tx and checks
// it against the bytes queued when they were offered.
module tb_uart_tx_core;

    localparam int CPB = 4;
    localparam int DW  = 8;

    logic          clk      = 1'b0;
    logic          rstn     = 1'b0;
    logic [DW-1:0] tx_data  = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic          tx;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] exp_q[$];
    int         start_q[$];

    uart_tx_core #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DW)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx      (tx),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold tx_valid until an edge on which tx_ready was high, then drop it.
    task automatic offer(input logic [7:0] d, input bit expect_frame, output int acc_cyc);
        bit ok;
        int n;
        n        = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        if (expect_frame) exp_q.push_back(d);
        do begin
            ok = tx_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 200);
        check("accept_seen", 32'(ok), 1);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        acc_cyc  = cyc;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 500) begin
            step(1);
            n++;
        end
        check(tag, 32'(busy), 0);
    endtask

    initial begin : line_monitor
        logic [9:0] fr;
        bit         stable;
        bit         aborted;
        int         t0;
        forever begin
            @(negedge clk);
            if (rstn && tx === 1'b0) begin
                t0      = cyc;
                stable  = 1'b1;
                aborted = 1'b0;
                for (int b = 0; b < 10; b++) begin
                    for (int c = 0; c < CPB; c++) begin
                        if (!(b == 0 && c == 0)) @(negedge clk);
                        if (!rstn) aborted = 1'b1;
                        if (c == 0) fr[b] = tx;
                        else if (tx !== fr[b]) stable = 1'b0;
                    end
                end
                if (!aborted) begin
                    check("mon_start_bit", 32'(fr[0]), 0);
                    check("mon_stop_bit", 32'(fr[9]), 1);
                    check("mon_bit_stable", 32'(stable), 1);
                    check("mon_expected_avail", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) check("mon_data", 32'(fr[8:1]), 32'(exp_q.pop_front()));
                    start_q.push_back(t0);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : main
        int         a1, a2, a3;
        int         mism, nb, zeros;
        logic [9:0] frame;

        // Reset and idle line
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", 32'(tx), 1);
        check("rst_ready", 32'(tx_ready), 1);
        check("rst_busy", 32'(busy), 0);
        rstn = 1'b1;
        zeros = 0;
        for (int i = 0; i < 20; i++) begin
            tx_data = 8'($urandom);
            step(1);
            if (tx !== 1'b1) zeros++;
        end
        check("idle_tx_low_cycles", zeros, 0);
        check("idle_busy", 32'(busy), 0);
        check("idle_ready", 32'(tx_ready), 1);

        // Single byte 0x55
        offer(8'h55, 1'b1, a1);
        frame = {1'b1, 8'h55, 1'b0};
        mism  = 0;
        nb    = 0;
        for (int i = 0; i < 10 * CPB; i++) begin
            if (tx !== frame[i / CPB]) mism++;
            if (busy !== 1'b1) nb++;
            step(1);
        end
        check("s1_line_mismatch", mism, 0);
        check("s1_busy_low_cycles", nb, 0);
        check("s1_end_tx", 32'(tx), 1);
        check("s1_end_busy", 32'(busy), 0);

        // Back-to-back 0xA5, 0x3C, then 0xFF held while the buffer is full
        start_q.delete();
        offer(8'hA5, 1'b1, a1);
        step(1);
        offer(8'h3C, 1'b1, a2);
        check("b2b_accept_gap", a2 - a1, 2);
        check("b2b_ready_low", 32'(tx_ready), 0);
        check("b2b_busy", 32'(busy), 1);
        offer(8'hFF, 1'b1, a3);
        check("ff_accept_cycle", a3 - a1, 41);
        wait_idle("b2b_idle");
        check("b2b_frames", start_q.size(), 3);
        if (start_q.size() == 3) begin
            check("b2b_gap_1_2", start_q[1] - start_q[0], 10 * CPB);
            check("b2b_gap_2_3", start_q[2] - start_q[1], 10 * CPB);
        end

        // Reset during data bit 3 of 0x00
        start_q.delete();
        offer(8'h00, 1'b0, a1);
        step(16);
        check("rmid_tx_before", 32'(tx), 0);
        #2;
        rstn = 1'b0;
        #1;
        check("rmid_tx_async", 32'(tx), 1);
        check("rmid_busy_in_rst", 32'(busy), 0);
        step(2);
        rstn = 1'b1;
        check("rmid_ready", 32'(tx_ready), 1);
        check("rmid_busy", 32'(busy), 0);
        zeros = 0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (tx !== 1'b1) zeros++;
        end
        check("rmid_residual_low_cycles", zeros, 0);
        check("rmid_no_frames", start_q.size(), 0);

        // Accept on the last STOP cycle with the buffer empty
        start_q.delete();
        offer(8'hC3, 1'b1, a1);
        step(10 * CPB - 1);
        offer(8'h81, 1'b1, a2);
        check("stopacc_edge", a2 - a1, 10 * CPB);
        check("stopacc_start_bit", 32'(tx), 0);
        wait_idle("stopacc_idle");
        check("stopacc_frames", start_q.size(), 2);
        if (start_q.size() == 2) check("stopacc_gap", start_q[1] - start_q[0], 10 * CPB);

        step(5);
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
